// File: rtl/ifu_prefetch_queue.sv
// ifu_prefetch_queue
// Instruction fetch front end: PC generator, in-order request/response port to
// instruction memory, and a DEPTH-entry fetch queue feeding the IF/ID register.
// Fetch keeps running while decode stalls, up to the queue capacity. A redirect
// flushes the queue and arranges for responses of requests already in flight
// to be discarded on arrival.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   redirect_valid, redirect_pc   one-cycle flush pulse and new fetch target
//   imem_req_valid/ready/addr     fetch request channel
//   imem_rsp_valid/data           fetch response channel, strictly in request order
//   m_valid, m_ready              head-of-queue handshake towards IF/ID
//   if_id_bus                     {pc, instr, pc+4}, pc in the MSBs; zero when idle
module ifu_prefetch_queue #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               redirect_valid,
    input  logic [PC_WIDTH-1:0]                redirect_pc,
    output logic                               imem_req_valid,
    input  logic                               imem_req_ready,
    output logic [PC_WIDTH-1:0]                imem_req_addr,
    input  logic                               imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]             imem_rsp_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [2*PC_WIDTH+INSTR_WIDTH-1:0]  if_id_bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    pc_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]       filled;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W-1:0]       fill_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       drop_cnt;
    // Allocated entries still waiting for their response. Kept as its own
    // counter because fill_ptr == tail is ambiguous on a full queue.
    logic [CNT_W-1:0]       pend_cnt;

    logic                   req_fire;
    logic                   deq;
    logic                   rsp_drop;
    logic                   rsp_fill;
    logic                   rsp_take;
    logic [CNT_W:0]         credit_used;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [PC_WIDTH-1:0]    head_pc_next;

    // Credit covers both live entries and stale responses still to arrive, so
    // the memory never holds more than DEPTH outstanding requests.
    assign credit_used    = {1'b0, count} + {1'b0, drop_cnt};
    assign imem_req_valid = ~rst & ~redirect_valid & (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & (pend_cnt != '0);
    assign rsp_take = rsp_drop | rsp_fill;

    assign m_valid      = ~rst & (count != '0) & filled[head];
    assign deq          = m_valid & m_ready;
    assign head_pc      = pc_q[head];
    assign head_pc_next = head_pc + PC_WIDTH'(4);
    assign if_id_bus    = m_valid ? {head_pc, instr_q[head], head_pc_next} : '0;

    // Payload storage needs no reset: validity lives in count/filled.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[tail] <= fetch_pc;
        end
        if (rsp_fill) begin
            instr_q[fill_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            drop_cnt <= '0;
            pend_cnt <= '0;
            filled   <= '0;
        end else if (redirect_valid) begin
            // No request fires this cycle; a same-cycle response retires one
            // outstanding slot (filled or dropped) before the rest are turned
            // into stale responses to drop.
            fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend_cnt <= '0;
            filled   <= '0;
            drop_cnt <= drop_cnt + pend_cnt - CNT_W'(rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc     <= fetch_pc + PC_WIDTH'(4);
                tail         <= tail + PTR_W'(1);
                filled[tail] <= 1'b0;
            end
            if (rsp_fill) begin
                filled[fill_ptr] <= 1'b1;
                fill_ptr         <= fill_ptr + PTR_W'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count    <= count + CNT_W'(req_fire) - CNT_W'(deq);
            pend_cnt <= pend_cnt + CNT_W'(req_fire) - CNT_W'(rsp_fill);
        end
    end

    rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (drop_cnt != '0 || pend_cnt != '0));

    credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_used <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
module tb_ifu_prefetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [95:0] if_id_bus;

    ifu_prefetch_queue #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .m_valid(m_valid), .m_ready(m_ready), .if_id_bus(if_id_bus)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] addr; } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          mcyc = 0;
    int          last_due = 0;
    int          lat_fixed = 1;
    bit          rand_mode = 1'b0;
    int          fires = 0;
    int          inv_bad = 0;
    time         first_fire_t = 0;
    time         first_mv_t = 0;
    bit          seen_fire = 1'b0;
    bit          seen_mv = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [95:0] exp_bus(input logic [31:0] pc);
        return {pc, instr_of(pc), pc + 32'd4};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Called at posedge+1; returns at posedge+1 with m_ready low.
    task automatic drain(input string name, input int bound);
        m_ready = 1'b1;
        for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: drain timeout, %0d entries left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        m_ready = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Instruction memory: in-order, configurable latency, flushed by reset.
    always @(negedge clk) begin
        mcyc++;
        if (rst) begin
            mem_q.delete();
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b0;
            last_due = mcyc;
        end else begin
            if (mem_q.size() > 0 && mem_q[0].due <= mcyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            imem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (imem_req_valid && imem_req_ready) begin
                mreq_t r;
                int lat;
                lat = rand_mode ? int'($urandom_range(1, 4)) : lat_fixed;
                r.due = mcyc + lat;
                if (r.due <= last_due) r.due = last_due + 1;
                r.addr = imem_req_addr;
                last_due = r.due;
                mem_q.push_back(r);
                fires++;
                if (!seen_fire) begin
                    seen_fire = 1'b1;
                    first_fire_t = $time;
                end
            end
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst && (int'(dut.count) + int'(dut.drop_cnt) > DEPTH)) inv_bad++;
        if (m_valid && !seen_mv) begin
            seen_mv = 1'b1;
            first_mv_t = $time;
        end
        if (!m_valid) begin
            check("idle_bus_zero", if_id_bus, 96'd0);
        end else if (m_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got %h expected none", if_id_bus);
            end else begin
                logic [31:0] pc;
                pc = exp_q.pop_front();
                check("if_id_bus", if_id_bus, exp_bus(pc));
            end
        end
    end

    initial begin
        bit trig;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 96'(imem_req_valid), 96'd0);
        check("rst_m_valid", 96'(m_valid), 96'd0);
        check("rst_bus", if_id_bus, 96'd0);

        // Streaming, 1-cycle memory, decode always ready
        rst = 1'b0;
        #1;
        check("first_req_valid", 96'(imem_req_valid), 96'd1);
        check("first_req_addr", 96'(imem_req_addr), 96'(RST_PC));
        push_seq(RST_PC, 8);
        drain("stream", 100);
        check("mvalid_latency", 96'(first_mv_t - first_fire_t), 96'd20);

        // Decode stalled: queue fills, fetch stops
        wait_cycles(10);
        check("full_req_valid", 96'(imem_req_valid), 96'd0);
        check("full_m_valid", 96'(m_valid), 96'd1);
        check("full_head_bus", if_id_bus, exp_bus(32'h8000_0020));
        check("fires_after_fill", 96'(fires), 96'd12);
        push_seq(32'h8000_0020, 8);
        drain("resume", 100);
        wait_cycles(10);
        check("fires_after_resume", 96'(fires), 96'd20);

        // Long latency, three in flight, redirect to unaligned target
        lat_fixed = 5;
        push_seq(32'h8000_0040, 3);
        drain("pop3", 50);
        @(posedge clk); #1;
        check("in_flight", 96'(mem_q.size()), 96'd3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_1002;
        #1;
        check("redirect_blocks_req", 96'(imem_req_valid), 96'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        check("redir_req_valid", 96'(imem_req_valid), 96'd1);
        check("redir_req_addr", 96'(imem_req_addr), 96'h8000_1000);
        check("redir_m_valid", 96'(m_valid), 96'd0);
        push_seq(32'h8000_1000, 8);
        drain("after_redirect", 300);
        wait_cycles(20);

        // Redirect coinciding with a response and a dequeue handshake
        lat_fixed = 2;
        push_seq(32'h8000_1020, 8);
        m_ready = 1'b1;
        trig = 1'b0;
        for (int i = 0; i < 30 && !trig; i++) begin
            @(posedge clk); #1;
            if (m_valid && mem_q.size() > 0 && mem_q[0].due <= mcyc + 1) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h8000_2001;
                trig = 1'b1;
            end
        end
        check("collision_found", 96'(trig), 96'd1);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        #1;
        check("coll_req_addr", 96'(imem_req_addr), 96'h8000_2000);
        push_seq(32'h8000_2000, 8);
        drain("after_collision", 200);
        wait_cycles(15);

        // Back-to-back redirects, last one wins
        lat_fixed = 4;
        push_seq(32'h8000_2020, 2);
        drain("pop2", 50);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_3000;
        @(posedge clk); #1;
        redirect_pc = 32'h8000_4000;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        check("b2b_req_addr", 96'(imem_req_addr), 96'h8000_4000);
        push_seq(32'h8000_4000, 8);
        drain("after_b2b", 300);

        // Random request backpressure and response latency
        rand_mode = 1'b1;
        push_seq(32'h8000_4020, 40);
        drain("random", 1500);
        rand_mode = 1'b0;
        lat_fixed = 1;
        wait_cycles(15);
        check("random_full_m_valid", 96'(m_valid), 96'd1);

        // Reset mid-stream with entries queued
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid", 96'(imem_req_valid), 96'd0);
        check("mid_rst_m_valid", 96'(m_valid), 96'd0);
        check("mid_rst_bus", if_id_bus, 96'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_m_valid", 96'(m_valid), 96'd0);
        check("post_rst_req_addr", 96'(imem_req_addr), 96'(RST_PC));
        push_seq(RST_PC, 6);
        drain("after_reset", 100);

        check("credit_invariant_violations", 96'(inv_bad), 96'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch_queue.md
Name: ifu_prefetch_queue

Overview:
- Parametrised next-generation instruction fetch front end: PC generator, variable-latency instruction-memory request/response port, and a DEPTH-entry in-order fetch queue.
- Sits between the branch/redirect logic and the IF/ID pipeline register.
- Decouples fetch from decode so fetch continues while decode stalls.
- Redirects flush the queue and discard stale in-flight memory responses.
- Emits {PC, Instr, PC+4} per entry with valid/ready handshake.

Parameters:
PC_WIDTH, 32, PC and memory address width
INSTR_WIDTH, 32, instruction width
DEPTH, 4, queue entries (power of two, >=2); also bounds in-flight requests
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
redirect_valid  input  1  branch taken / flush; 1-cycle pulse
redirect_pc  input  PC_WIDTH  new fetch target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  PC_WIDTH  fetch address
imem_rsp_valid  input  1  response valid; responses strictly in request order
imem_rsp_data  input  INSTR_WIDTH  fetched instruction
m_valid  output  1  head entry valid to IF/ID
m_ready  input  1  IF/ID accepts
if_id_bus  output  2*PC_WIDTH+INSTR_WIDTH  {PC, Instr, PC+4}, PC in MSBs

Behaviour:
- Reset (sync, rst=1 at posedge): fetch_pc=RESET_PC; queue empty (head=tail=fill ptr=0, count=0); drop_cnt=0. While rst=1: imem_req_valid=0, m_valid=0, if_id_bus=0. rst mid-operation discards everything; responses arriving during/after reset for pre-reset requests are not tracked (memory is reset too).
- Entry = {pc, instr, filled}. Entry allocated at tail on request fire (imem_req_valid & imem_req_ready), storing pc=fetch_pc, filled=0. Same edge: fetch_pc += 4 (mod 2^PC_WIDTH, wrap permitted).
- Response: if drop_cnt>0, discard, drop_cnt -= 1. Otherwise write imem_rsp_data into entry at fill ptr, set filled, advance fill ptr. Response with nothing outstanding is a protocol error (assertion), ignored.
- imem_req_valid = ~rst & ~redirect_valid & (count + drop_cnt < DEPTH); imem_req_addr=fetch_pc. Once asserted, held with stable address until fire or redirect.
- m_valid = head entry allocated & filled. if_id_bus = {pc, instr, pc+4} of head; zero when m_valid=0. Combinational from queue state, not from imem_rsp (min latency response->m_valid = 1 cycle).
- Dequeue on m_valid & m_ready: head advances, count -= 1.
- Same-cycle allocate+dequeue: count unchanged; full queue with dequeue still blocks request that cycle (credit check uses registered count).
- Redirect (redirect_valid=1 at posedge): the dequeue handshake that cycle completes (entry consumed); all remaining entries invalidated; count=0; pointers reset to 0; fetch_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00}; drop_cnt = (drop_cnt + allocated-unfilled entries) minus 1 if a response is accepted that cycle. A same-cycle response is counted against the old state (filling/discarding per rules above) before the flush. No request issues in the redirect cycle; the first request to the target appears the next cycle.
- Back-to-back redirects: last one wins; drop_cnt accumulates correctly.
- Pointer arithmetic: log2(DEPTH)-bit pointers, wrap modulo DEPTH; count and drop_cnt are log2(DEPTH)+1 bits; invariant count+drop_cnt <= DEPTH.

Test Plan:
- Reset, imem 1-cycle latency, m_ready=1 -> requests 0x80000000, 0x80000004, ... every cycle; m_valid 2 cycles after first fire; if_id_bus = {0x80000000, instr0, 0x80000004}.
- m_ready=0 with DEPTH=4 -> exactly 4 requests fired, then imem_req_valid=0; raising m_ready delivers 4 entries in order, then fetch resumes at 0x80000010.
- Memory latency 5 cycles with 3 in flight, redirect_valid with redirect_pc=0x80001002 -> 3 stale responses discarded; next req_addr=0x80001000; first m_valid entry has PC=0x80001000.
- Redirect in the same cycle as a stale response and an m_ready handshake -> handshaken entry consumed once, response counted (drop_cnt correct), no stale instruction ever reaches if_id_bus.
- imem_req_ready random 50%, rsp latency random 1-4 -> output PC stream strictly +4, instructions match address, count+drop_cnt never exceeds DEPTH.
- Assert rst for one cycle mid-stream with entries queued -> next cycle m_valid=0, fetch restarts at 0x80000000.
